// File: rtl/r_forward_buffer_pkg.sv
// Shared AR forward-flit definitions: field widths, flit width, bit offsets
// and the packing helper used by every stage that touches the AR flit.
package r_forward_buffer_pkg;

    localparam int AR_ID_W     = 8;
    localparam int AR_ADDR_W   = 36;
    localparam int AR_LEN_W    = 8;
    localparam int AR_SIZE_W   = 3;
    localparam int AR_BURST_W  = 2;
    localparam int AR_LOCK_W   = 1;
    localparam int AR_CACHE_W  = 4;
    localparam int AR_PROT_W   = 3;
    localparam int AR_QOS_W    = 4;
    localparam int AR_REGION_W = 4;
    localparam int AR_USER_W   = 4;

    localparam int AR_FLIT_W   = 77;

    // LSB offsets of each field inside the flit (ARID occupies the MSBs)
    localparam int AR_USER_LSB   = 0;
    localparam int AR_REGION_LSB = 4;
    localparam int AR_QOS_LSB    = 8;
    localparam int AR_PROT_LSB   = 12;
    localparam int AR_CACHE_LSB  = 15;
    localparam int AR_LOCK_LSB   = 19;
    localparam int AR_BURST_LSB  = 20;
    localparam int AR_SIZE_LSB   = 22;
    localparam int AR_LEN_LSB    = 25;
    localparam int AR_ADDR_LSB   = 33;
    localparam int AR_ID_LSB     = 69;

    typedef logic [AR_FLIT_W-1:0] ar_flit_t;

    // Concatenate the AR fields into one flit, ARID in the MSBs
    function automatic ar_flit_t pack_ar_flit(
        input logic [AR_ID_W-1:0]     id,
        input logic [AR_ADDR_W-1:0]   addr,
        input logic [AR_LEN_W-1:0]    len,
        input logic [AR_SIZE_W-1:0]   size,
        input logic [AR_BURST_W-1:0]  burst,
        input logic [AR_LOCK_W-1:0]   lock,
        input logic [AR_CACHE_W-1:0]  cache,
        input logic [AR_PROT_W-1:0]   prot,
        input logic [AR_QOS_W-1:0]    qos,
        input logic [AR_REGION_W-1:0] region,
        input logic [AR_USER_W-1:0]   user
    );
        return {id, addr, len, size, burst, lock, cache, prot, qos, region, user};
    endfunction

endpackage

// File: rtl/r_forward_buffer_fifo.sv
// Generic first-word-fall-through synchronous FIFO with registered
// in_ready/out_valid and an occupancy output. Fullness is tracked with a
// counter so pointers can wrap freely. Output data reads as zero while empty.
module axi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_in_ready;
    logic             r_out_valid;

    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count_next;

    assign w_push = in_valid & r_in_ready;
    assign w_pop  = r_out_valid & out_ready;

    // Next occupancy from this cycle's push/pop pair
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Pointers, occupancy and registered handshake flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count     <= w_count_next;
            r_in_ready  <= (w_count_next != DEPTH_C);
            r_out_valid <= (w_count_next != CNT_W'(0));
        end
    end

    // Storage write; the array itself is deliberately left unreset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_valid ? r_mem[r_rd_ptr] : '0;
    assign level     = r_count;

endmodule

// File: rtl/r_forward_buffer.sv
// Read-address forward-path buffer: packs AXI4 AR beats into the 77-bit
// forward flit and queues them in a FWFT FIFO ahead of the separator, so
// ARREADY never depends combinationally on downstream READY.
module r_forward_buffer
    import r_forward_buffer_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic                   CLK,
    input  logic                   RESETn,
    input  logic [AR_ID_W-1:0]     ARID,
    input  logic [AR_ADDR_W-1:0]   ARADDR,
    input  logic [AR_LEN_W-1:0]    ARLEN,
    input  logic [AR_SIZE_W-1:0]   ARSIZE,
    input  logic [AR_BURST_W-1:0]  ARBURST,
    input  logic [AR_LOCK_W-1:0]   ARLOCK,
    input  logic [AR_CACHE_W-1:0]  ARCACHE,
    input  logic [AR_PROT_W-1:0]   ARPROT,
    input  logic [AR_QOS_W-1:0]    ARQOS,
    input  logic [AR_REGION_W-1:0] ARREGION,
    input  logic [AR_USER_W-1:0]   ARUSER,
    input  logic                   ARVALID,
    output logic                   ARREADY,
    output logic [AR_FLIT_W-1:0]   DATA,
    output logic                   VALID,
    input  logic                   READY,
    output logic [LEVEL_W-1:0]     LEVEL
);

    ar_flit_t                  w_flit;
    logic [$clog2(DEPTH):0]    w_level;

    assign w_flit = pack_ar_flit(ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK,
                                 ARCACHE, ARPROT, ARQOS, ARREGION, ARUSER);

    axi_sync_fifo #(
        .WIDTH (AR_FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RESETn),
        .in_data   (w_flit),
        .in_valid  (ARVALID),
        .in_ready  (ARREADY),
        .out_data  (DATA),
        .out_valid (VALID),
        .out_ready (READY),
        .level     (w_level)
    );

    assign LEVEL = LEVEL_W'(w_level);

endmodule
